// File: rtl/uart_i2c_top.sv
// UART-to-I2C bridge. Two 8N1 bytes from the host form one command. The command
// runs as a single-byte I2C master write or read. One status/data byte goes back
// to the host on rx.
module uart_i2c_top #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600,
  parameter int I2C_FREQ = 100_000
) (
  input  logic clk,
  input  logic rst,
  input  logic tx,
  output logic rx,
  inout  wire  scl,
  inout  wire  sda
);

  localparam int DIV    = (CLK_FREQ + BAUD * 8) / (BAUD * 16);
  localparam int QDIV   = (CLK_FREQ + I2C_FREQ * 2) / (I2C_FREQ * 4);
  localparam int BITCLK = DIV * 16;
  localparam int DW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int QW     = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam int BW     = $clog2(BITCLK);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_st_t;
  typedef enum logic [3:0] {IDLE, START, ADDR, AACK, DATA_W, DATA_R, DACK, STOP, RESP} i2c_st_t;

  logic [DW-1:0] rdiv;
  logic [QW-1:0] qdiv;
  logic          rtick, qtick;
  logic          tx_m, tx_s, tx_p, scl_m, scl_s, sda_m, sda_s;

  rx_st_t        rxst, rxst_n;
  logic [3:0]    rcnt, rcnt_n;
  logic [2:0]    rbit, rbit_n;
  logic [7:0]    rsh, rsh_n;
  logic          rx_vld;

  logic          bcnt, hold_full, take, cmd_done;
  logic [7:0]    b1;
  logic [15:0]   hold_cmd;

  logic [9:0]    tsh;
  logic [3:0]    tnb;
  logic [BW-1:0] tcnt;
  logic          tx_idle, tx_load;

  i2c_st_t       st, st_n;
  logic [1:0]    ph, ph_n;
  logic [2:0]    bitn, bitn_n;
  logic [7:0]    rdata, rdata_n, resp, resp_n, ob;
  logic [15:0]   cmd_q, cmd_n;
  logic          scl_q, scl_n, sda_q, sda_n;

  assign rtick    = (rdiv == DW'(DIV - 1));
  assign qtick    = (qdiv == QW'(QDIV - 1));
  assign cmd_done = rx_vld & bcnt;
  assign tx_idle  = (tnb == 4'd0);
  assign rx       = tsh[0];
  assign scl      = scl_q ? 1'bz : 1'b0;
  assign sda      = sda_q ? 1'bz : 1'b0;

  // free-running 16x baud tick and I2C quarter-phase tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdiv <= '0;
      qdiv <= '0;
    end else begin
      rdiv <= rtick ? '0 : rdiv + 1'b1;
      qdiv <= qtick ? '0 : qdiv + 1'b1;
    end
  end

  // two-flop synchronisers for the async inputs; tx_p holds the previous synced tx
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {tx_m, tx_s, tx_p}       <= 3'b111;
      {scl_m, scl_s, sda_m, sda_s} <= 4'b1111;
    end else begin
      {tx_m, tx_s, tx_p}       <= {tx, tx_m, tx_s};
      {scl_m, scl_s, sda_m, sda_s} <= {scl, scl_m, sda, sda_m};
    end
  end

  // UART receiver state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxst <= R_IDLE;
      rcnt <= '0;
      rbit <= '0;
      rsh  <= '0;
    end else begin
      rxst <= rxst_n;
      rcnt <= rcnt_n;
      rbit <= rbit_n;
      rsh  <= rsh_n;
    end
  end

  // UART receiver: start checked on the 7th tick, then every bit 16 ticks later,
  // so sampling sits slightly before mid-bit and survives a half-length bit 7
  always_comb begin
    rxst_n = rxst;
    rcnt_n = rcnt;
    rbit_n = rbit;
    rsh_n  = rsh;
    rx_vld = 1'b0;
    case (rxst)
      R_IDLE: if (tx_p && !tx_s) begin
        rxst_n = R_START;
        rcnt_n = 4'd0;
      end
      R_START: if (rtick) begin
        if (rcnt == 4'd6) begin
          rcnt_n = 4'd0;
          rbit_n = 3'd0;
          rxst_n = tx_s ? R_IDLE : R_DATA;
        end else begin
          rcnt_n = rcnt + 4'd1;
        end
      end
      R_DATA: if (rtick) begin
        rcnt_n = rcnt + 4'd1;
        if (rcnt == 4'd15) begin
          rsh_n  = {tx_s, rsh[7:1]};
          rbit_n = rbit + 3'd1;
          if (rbit == 3'd7) rxst_n = R_STOP;
        end
      end
      R_STOP: if (rtick) begin
        rcnt_n = rcnt + 4'd1;
        if (rcnt == 4'd15) begin
          rx_vld = tx_s;  // low stop bit: framing error, byte dropped
          rxst_n = R_IDLE;
        end
      end
      default: rxst_n = R_IDLE;
    endcase
  end

  // command framing and the one-entry holding buffer; a take in the same cycle frees the slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt      <= 1'b0;
      b1        <= '0;
      hold_full <= 1'b0;
      hold_cmd  <= '0;
    end else begin
      if (rx_vld) begin
        bcnt <= ~bcnt;
        if (!bcnt) b1 <= rsh;
      end
      if (cmd_done && (!hold_full || take)) begin
        hold_full <= 1'b1;
        hold_cmd  <= {b1, rsh};
      end else if (take) begin
        hold_full <= 1'b0;
      end
    end
  end

  // UART transmitter: {stop, data, start} shifted out LSB first, each bit BITCLK clocks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tsh  <= '1;
      tnb  <= '0;
      tcnt <= '0;
    end else if (tx_load) begin
      tsh  <= {1'b1, resp, 1'b0};
      tnb  <= 4'd10;
      tcnt <= '0;
    end else if (tnb != 4'd0) begin
      if (tcnt == BW'(BITCLK - 1)) begin
        tcnt <= '0;
        tsh  <= {1'b1, tsh[9:1]};
        tnb  <= tnb - 4'd1;
      end else begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

  // I2C master state register; bus drivers are registered so reset releases them at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st    <= IDLE;
      ph    <= '0;
      bitn  <= '0;
      rdata <= '0;
      resp  <= '0;
      cmd_q <= '0;
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      st    <= st_n;
      ph    <= ph_n;
      bitn  <= bitn_n;
      rdata <= rdata_n;
      resp  <= resp_n;
      cmd_q <= cmd_n;
      scl_q <= scl_n;
      sda_q <= sda_n;
    end
  end

  // I2C master: per bit, ph0 sets SDA (SCL low), ph1 releases SCL, ph2 waits for
  // SCL high (stretching) and samples, ph3 pulls SCL low
  always_comb begin
    st_n    = st;
    ph_n    = ph;
    bitn_n  = bitn;
    rdata_n = rdata;
    resp_n  = resp;
    cmd_n   = cmd_q;
    scl_n   = scl_q;
    sda_n   = sda_q;
    take    = 1'b0;
    tx_load = 1'b0;
    ob      = (st == ADDR) ? cmd_q[15:8] : cmd_q[7:0];
    case (st)
      IDLE: begin
        scl_n = 1'b1;
        sda_n = 1'b1;
        if (hold_full && tx_idle) begin
          take  = 1'b1;
          cmd_n = hold_cmd;
          st_n  = START;
          ph_n  = 2'd0;
        end
      end
      START: if (qtick) begin
        if (ph == 2'd0) begin
          sda_n = 1'b0;
          ph_n  = 2'd1;
        end else begin
          scl_n  = 1'b0;
          ph_n   = 2'd0;
          bitn_n = 3'd0;
          st_n   = ADDR;
        end
      end
      ADDR, AACK, DATA_W, DATA_R, DACK: if (qtick) begin
        case (ph)
          2'd0: begin
            sda_n = (st == ADDR || st == DATA_W) ? ob[~bitn] : 1'b1;
            ph_n  = 2'd1;
          end
          2'd1: begin
            scl_n = 1'b1;
            ph_n  = 2'd2;
          end
          2'd2: if (scl_s) begin
            ph_n = 2'd3;
            case (st)
              AACK:    resp_n  = sda_s ? 8'hE1 : 8'h00;
              DATA_R:  rdata_n = {rdata[6:0], sda_s};
              DACK:    resp_n  = cmd_q[8] ? rdata : (sda_s ? 8'hE2 : 8'h00);
              default: ;
            endcase
          end
          default: begin
            scl_n  = 1'b0;
            ph_n   = 2'd0;
            bitn_n = bitn + 3'd1;
            case (st)
              ADDR:           if (bitn == 3'd7) st_n = AACK;
              AACK: begin
                bitn_n = 3'd0;
                st_n   = (resp == 8'hE1) ? STOP : (cmd_q[8] ? DATA_R : DATA_W);
              end
              DATA_W, DATA_R: if (bitn == 3'd7) st_n = DACK;
              default:        st_n = STOP;
            endcase
          end
        endcase
      end
      STOP: if (qtick) begin
        case (ph)
          2'd0: begin
            sda_n = 1'b0;
            ph_n  = 2'd1;
          end
          2'd1: begin
            scl_n = 1'b1;
            ph_n  = 2'd2;
          end
          2'd2: if (scl_s) ph_n = 2'd3;
          default: begin
            sda_n   = 1'b1;
            tx_load = 1'b1;
            st_n    = RESP;
            ph_n    = 2'd0;
          end
        endcase
      end
      RESP: if (qtick) begin
        // one idle SCL period on the bus before another START
        ph_n = ph + 2'd1;
        if (ph == 2'd3) st_n = IDLE;
      end
      default: st_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_i2c_top.sv
// Bench for uart_i2c_top: host UART driver, I2C slave model that checks each bus
// transaction at STOP, and a UART monitor that checks every response byte.
module tb_uart_i2c_top;
  localparam int CLK_FREQ = 6_400_000;
  localparam int BAUD     = 100_000;
  localparam int I2C_FREQ = 400_000;
  localparam int BIT      = 64;   // 16 ticks of 4 clocks
  localparam int SCLP     = 16;   // 4 quarters of 4 clocks

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx  = 1'b1;
  logic rx;
  wire  scl, sda;
  logic sl_drv = 1'b0;

  pullup (scl);
  pullup (sda);
  assign sda = sl_drv ? 1'b0 : 1'bz;

  uart_i2c_top #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .I2C_FREQ(I2C_FREQ)) dut (
    .clk(clk), .rst(rst), .tx(tx), .rx(rx), .scl(scl), .sda(sda));

  always #5 clk = ~clk;

  int vectors = 0, errors = 0;
  int starts = 0, scl_falls = 0, rx_falls = 0;
  logic [7:0]  exp_rx[$];
  logic [15:0] exp_bus[$];
  logic [7:0]  rd_q[$];
  bit slave_en = 1'b1, data_nack = 1'b0;

  always @(negedge scl) scl_falls++;
  always @(negedge rx) rx_falls++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit short7, input bit badstop, input int gap);
    @(negedge clk);
    tx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      tx = b[i];
      repeat ((i == 7 && short7) ? BIT / 2 : BIT) @(negedge clk);
    end
    tx = badstop ? 1'b0 : 1'b1;
    repeat (BIT) @(negedge clk);
    tx = 1'b1;
    repeat (gap * BIT) @(negedge clk);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((exp_rx.size() != 0 || exp_bus.size() != 0) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (exp_rx.size() != 0 || exp_bus.size() != 0) begin
      vectors++;
      errors++;
      $display("FAIL %s timeout: %0d rx and %0d bus expectations left, want 0",
               name, exp_rx.size(), exp_bus.size());
      exp_rx.delete();
      exp_bus.delete();
    end
    repeat (BIT) @(negedge clk);
  endtask

  // I2C slave model; logs {addr byte, data byte or master ack bit} at STOP
  initial begin : slave
    logic [7:0] a, d, rb;
    forever begin
      do @(negedge sda); while (scl !== 1'b1);
      starts++;
      a = '0;
      d = '0;
      for (int i = 0; i < 8; i++) begin
        @(posedge scl);
        a = {a[6:0], sda};
      end
      @(negedge scl);
      if (slave_en) sl_drv = 1'b1;
      @(negedge scl);
      sl_drv = 1'b0;
      if (slave_en && !a[0]) begin
        for (int i = 0; i < 8; i++) begin
          @(posedge scl);
          d = {d[6:0], sda};
        end
        @(negedge scl);
        if (!data_nack) sl_drv = 1'b1;
        @(negedge scl);
        sl_drv = 1'b0;
      end else if (slave_en) begin
        rb = (rd_q.size() != 0) ? rd_q.pop_front() : 8'hFF;
        sl_drv = ~rb[7];
        for (int i = 6; i >= 0; i--) begin
          @(negedge scl);
          sl_drv = ~rb[i];
        end
        @(negedge scl);
        sl_drv = 1'b0;
        @(posedge scl);
        d = {7'd0, sda};
      end
      do @(posedge sda); while (scl !== 1'b1);
      if (exp_bus.size() == 0) check("bus unexpected", 32'({a, d}), 32'hFFFF_FFFF);
      else check("bus", 32'({a, d}), 32'(exp_bus.pop_front()));
    end
  end

  // UART monitor on rx
  initial begin : rxmon
    logic [7:0] b;
    logic stp;
    forever begin
      @(negedge rx);
      repeat (BIT / 2) @(negedge clk);
      b = '0;
      for (int i = 0; i < 8; i++) begin
        repeat (BIT) @(negedge clk);
        b[i] = rx;
      end
      repeat (BIT) @(negedge clk);
      stp = rx;
      if (exp_rx.size() == 0) check("rx unexpected", 32'({stp, b}), 32'hFFFF_FFFF);
      else check("rx byte+stop", 32'({stp, b}), 32'({1'b1, exp_rx.pop_front()}));
    end
  end

  initial begin : stim
    int f0, r0, s0, n;
    repeat (5) @(negedge clk);
    check("reset rx", 32'(rx), 32'd1);
    check("reset scl", 32'(scl), 32'd1);
    check("reset sda", 32'(sda), 32'd1);
    rst = 1'b0;
    f0 = scl_falls;
    r0 = rx_falls;
    repeat (10 * BIT) @(negedge clk);
    check("idle scl activity", 32'(scl_falls - f0), 32'd0);
    check("idle rx activity", 32'(rx_falls - r0), 32'd0);

    // write, slave ACKs
    exp_bus.push_back({8'hA4, 8'h5A}); exp_rx.push_back(8'h00);
    send_byte(8'hA4, 0, 0, 1); send_byte(8'h5A, 0, 0, 1);
    wait_done("write ack");

    // read, slave returns 0x3C, master NACKs
    rd_q.push_back(8'h3C);
    exp_bus.push_back({8'hA5, 8'h01}); exp_rx.push_back(8'h3C);
    send_byte(8'hA5, 0, 0, 1); send_byte(8'h00, 0, 0, 1);
    wait_done("read");

    // write, slave NACKs data
    data_nack = 1'b1;
    exp_bus.push_back({8'hA4, 8'h77}); exp_rx.push_back(8'hE2);
    send_byte(8'hA4, 0, 0, 1); send_byte(8'h77, 0, 0, 1);
    wait_done("data nack");
    data_nack = 1'b0;

    // no slave: address NACK
    slave_en = 1'b0;
    exp_bus.push_back({8'h01, 8'h00}); exp_rx.push_back(8'hE1);
    send_byte(8'h01, 0, 0, 1); send_byte(8'h02, 0, 0, 1);
    wait_done("addr nack");
    slave_en = 1'b1;

    // shortened bit 7 on every byte, 2-bit gaps: two reads
    rd_q.push_back(8'h96); rd_q.push_back(8'h6B);
    exp_bus.push_back({8'hA5, 8'h01}); exp_bus.push_back({8'h01, 8'h01});
    exp_rx.push_back(8'h96); exp_rx.push_back(8'h6B);
    send_byte(8'hA5, 1, 0, 2); send_byte(8'h00, 1, 0, 2);
    send_byte(8'h01, 1, 0, 2); send_byte(8'h02, 1, 0, 2);
    wait_done("short bit7");

    // framing error on first byte is discarded
    exp_bus.push_back({8'hA4, 8'hC3}); exp_rx.push_back(8'h00);
    send_byte(8'h13, 0, 1, 1); send_byte(8'hA4, 0, 0, 1); send_byte(8'hC3, 0, 0, 1);
    wait_done("framing error");

    // reset in the middle of the address phase
    s0 = starts;
    send_byte(8'hA4, 0, 0, 1); send_byte(8'h5A, 0, 0, 0);
    n = 0;
    while (starts == s0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("abort start seen", 32'(starts != s0), 32'd1);
    repeat (2 * SCLP) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort scl released", 32'(scl), 32'd1);
    check("abort sda released", 32'(sda), 32'd1);
    check("abort rx", 32'(rx), 32'd1);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    f0 = scl_falls;
    r0 = rx_falls;
    repeat (10 * BIT) @(negedge clk);
    check("post-abort scl activity", 32'(scl_falls - f0), 32'd0);
    check("post-abort rx activity", 32'(rx_falls - r0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
